// File: rtl/addr8s_sched_pkg.sv
// Shared types, widths and the round-robin grant function for the dual-pass adder scheduler.
package addr8s_sched_pkg;

    localparam int OP_W     = 8;
    localparam int SUM_W    = 9;
    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    // One-hot grant to the first valid requester at or after ptr, wrapping at n.
    function automatic logic [MAX_NREQ-1:0] rr_grant(
        input logic [MAX_NREQ-1:0] valid,
        input logic [2:0]          ptr,
        input int                  n
    );
        logic [MAX_NREQ-1:0] grant;
        logic                found;
        logic [2:0]          idx;
        int                  pos;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= n) pos = pos - n;
            idx = 3'(pos);
            if (!found && k < n && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/addr8s_core.sv
// Combinational 8+8 -> 9 bit signed adder; the 9-bit result can never overflow.
module addr8s_core
    import addr8s_sched_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [SUM_W-1:0] sum
);

    assign sum = {a[OP_W-1], a} + {b[OP_W-1], b};

endmodule

// File: rtl/addr8s_sched.sv
// Round-robin scheduler sharing one adder core; each operation runs as (A,B) then (B,A)
// and the two passes are compared, retrying on mismatch and flagging exhausted retries.
module addr8s_sched
    import addr8s_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*OP_W-1:0]      req_a,
    input  logic [NREQ*OP_W-1:0]      req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [SUM_W-1:0]          rsp_sum,
    output logic                      rsp_err,
    output logic [7:0]                err_count,
    input  logic                      fi_en,
    input  logic [SUM_W-1:0]          fi_mask
);

    localparam int ID_W = $clog2(NREQ);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [2:0]        retry;
    logic [OP_W-1:0]   op_a, op_b;
    logic [ID_W-1:0]   id_q;
    logic [SUM_W-1:0]  s1, s2;
    logic              err_q;

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_id;
    logic              req_fire;
    logic [OP_W-1:0]   core_a, core_b;
    logic [SUM_W-1:0]  core_sum;
    logic              mismatch;
    logic              can_retry;

    assign grant     = NREQ'(rr_grant(MAX_NREQ'(req_valid), 3'(rr_ptr), NREQ));
    assign req_fire  = (state == IDLE) && (|grant);
    assign mismatch  = (core_sum != s1);
    assign can_retry = (retry < 3'(MAX_RETRY));

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_id = ID_W'(i);
        end
    end

    addr8s_core u_core (
        .a   (core_a),
        .b   (core_b),
        .sum (core_sum)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_fire) state_nxt = EXEC1;
            EXEC1:   state_nxt = EXEC2;
            EXEC2:   state_nxt = (mismatch && can_retry) ? EXEC1 : RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and operand steering: the second pass swaps operands on the same core
    always_comb begin
        req_ready = (state == IDLE) ? grant : '0;
        rsp_valid = (state == RESP);
        core_a    = (state == EXEC2) ? op_b : op_a;
        core_b    = (state == EXEC2) ? op_a : op_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            retry     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            id_q      <= '0;
            s1        <= '0;
            s2        <= '0;
            err_q     <= 1'b0;
            err_count <= '0;
        end else begin
            if (req_fire) begin
                op_a   <= req_a[grant_id*OP_W +: OP_W];
                op_b   <= req_b[grant_id*OP_W +: OP_W];
                id_q   <= grant_id;
                rr_ptr <= (int'(grant_id) == NREQ-1) ? '0 : grant_id + 1'b1;
                retry  <= '0;
                err_q  <= 1'b0;
            end
            if (state == EXEC1) s1 <= core_sum ^ (fi_en ? fi_mask : '0);
            if (state == EXEC2) begin
                s2 <= core_sum;
                if (mismatch) begin
                    if (can_retry) retry <= retry + 3'd1;
                    else           err_q <= 1'b1;
                end
            end
            if (state == RESP && rsp_ready && err_q && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    assign rsp_id  = id_q;
    assign rsp_sum = s2;
    assign rsp_err = err_q;

endmodule

// File: doc/addr8s_sched.md
# addr8s_sched

Round-robin scheduler that time-shares one 8-bit signed adder core among `NREQ` requesters. Every operation runs twice on the core, the second time with operands swapped, and the two results are compared. A mismatch is retried up to `MAX_RETRY` times; if the retries run out, the result is flagged. The block sits between client request ports and the single fault-resilient adder instance, and gives temporal-redundancy error detection on top of the adder's structural resilience.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `MAX_RETRY`, 2: extra dual-pass attempts after a mismatch (0..7).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester request.
- `req_ready`  out  NREQ  one-hot grant/accept.
- `req_a`  in  NREQ*8  signed operand A; requester i occupies bits [8i+7:8i].
- `req_b`  in  NREQ*8  signed operand B, same packing.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  clog2(NREQ)  index of the served requester.
- `rsp_sum`  out  9  signed A+B, two's complement, never overflows.
- `rsp_err`  out  1  passes still mismatched after all retries.
- `err_count`  out  8  saturating count of `rsp_err` responses.
- `fi_en`  in  1  test hook: XOR `fi_mask` onto the core output during EXEC1 only.
- `fi_mask`  in  9  fault-injection pattern.

## Operation
- States: IDLE, EXEC1, EXEC2, RESP.
- IDLE:
  - Grant is combinational round-robin over `req_valid`, searching from `rr_ptr`.
  - `req_ready[i]` = (state==IDLE) & grant[i].
  - On handshake: capture A, B and id; set `rr_ptr` = id+1 mod NREQ; clear `retry`; go to EXEC1.
  - No request: stay in IDLE.
- EXEC1: core(A,B) XOR (fi_en ? fi_mask : 0) is registered into `s1`; go to EXEC2.
- EXEC2: core(B,A) is registered into `s2` and compared with `s1`.
  - Equal: go to RESP with err=0.
  - Unequal and `retry` < MAX_RETRY: `retry`++, go to EXEC1.
  - Unequal and `retry` == MAX_RETRY: go to RESP with err=1.
- RESP:
  - `rsp_valid`=1, `rsp_sum`=`s2`, `rsp_id` and `rsp_err` held stable.
  - Go to IDLE when `rsp_ready`=1.
- `err_count` increments, saturating at 255, on each RESP handshake with err=1.
- Sum width rule: sign-extend both operands to 9 bits, then add. Range is −256..+254.
- Captured operands are immune to later changes on `req_a`/`req_b`.

## Timing
- Reset values: state IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_err`=0, `err_count`=0, `rr_ptr`=0, `retry`=0.
- Request handshake at cycle T → `rsp_valid` at T+3 when fault-free, or T+3+2k after k retries.
  - Worst case is T+3+2·MAX_RETRY.
- Throughput: at most one request per 4 cycles.
  - The next grant is at the earliest one cycle after the RESP handshake, because IDLE is entered after the response.
- Backpressure: while `rsp_ready`=0, all rsp outputs hold and `req_ready` stays 0.
- Simultaneous requests: only one is granted; the others keep `valid` asserted and wait.
- A requester that drops `valid` before being granted forfeits without side effects.
- `fi_en` is sampled only in EXEC1; its value in other states has no effect.
- Reset mid-operation: asynchronous return to reset values; the in-flight request is discarded with no response.

## Structure
- Shared package `addr8s_sched_pkg` holds:
  - the state enum (IDLE, EXEC1, EXEC2, RESP);
  - the constants OP_W=8 and SUM_W=9;
  - the round-robin grant function.
- Sub-module `addr8s_core`: purely combinational 8+8→9 signed adder.
  - Exactly one instance.
  - Its operand muxes select (A,B) or (B,A) by state.
- The rest stays in one module: FSM, arbiter, operand/result registers, comparator, error counter.

## Test plan
- Single requester 0, A=8'h7F, B=8'h01, `rsp_ready`=1 → `rsp_sum`=9'h080, err=0, `rsp_id`=0, `rsp_valid` exactly 3 cycles after the handshake.
- A=8'h80, B=8'h80 → `rsp_sum`=9'h100 (−256). A=8'hFF, B=8'h01 → `rsp_sum`=9'h000.
- All four requesters valid continuously from reset → grant order 0,1,2,3,0. With requester 1 only, after serving 2 → next grant is 1.
- `fi_en`=1, `fi_mask`=9'h001 during the first EXEC1 only → one retry, correct sum, err=0, latency 5. `fi_en` held high with MAX_RETRY=2 → latency 7, err=1, `err_count`=1, `rsp_sum` = correct `s2`.
- `rsp_ready` low for 5 cycles in RESP → rsp outputs stable, `req_ready` 0; release → IDLE, and the next grant follows 1 cycle later.
- `rst_n` pulsed low during EXEC2 → all outputs at reset values immediately; no response is emitted for the aborted request; normal service resumes.
